exp_unit_arbiter: RTL and testbench

Round-robin arbiter and pipeline scheduler that shares one fixed-latency pipelined function unit (the `Subsystem` exp core: clk_enable, In1, Out1) between two requesters. It issues up to one operand per cycle, tracks every in-flight operand with a requester tag, and returns each result to its owner through a one-entry response register. When a result cannot be delivered, the block freezes the unit through its clock enable. It replaces full-latency wait-per-element sequencing with fully pipelined issue.

---
 rtl/exp_unit_arbiter.sv | 117 +++++++++++
 tb/tb_exp_unit_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_unit_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exp_unit_arbiter: round-robin sharing of one pipelined exp unit by two     |
// | requesters, with per-slot owner tags and one-entry result registers. r1.0  |
// +----------------------------------------------------------------------------+
module exp_unit_arbiter #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 30,
  parameter int IW      = $clog2(LATENCY + 1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_data_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_data_i,
  output logic             rsp0_valid_o,
  input  logic             rsp0_ready_i,
  output logic [WIDTH-1:0] rsp0_data_o,
  output logic             rsp1_valid_o,
  input  logic             rsp1_ready_i,
  output logic [WIDTH-1:0] rsp1_data_o,
  output logic             unit_enable_o,
  output logic [WIDTH-1:0] unit_in_o,
  input  logic [WIDTH-1:0] unit_out_i,
  output logic [IW-1:0]    in_flight_o,
  output logic             busy_o
);

  logic [LATENCY-1:0] tag_v_q, tag_v_d;
  logic [LATENCY-1:0] tag_id_q, tag_id_d;
  logic               last_grant_q, last_grant_d;
  logic               rsp0_valid_q, rsp0_valid_d;
  logic               rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0]   rsp0_data_q, rsp0_data_d;
  logic [WIDTH-1:0]   rsp1_data_q, rsp1_data_d;

  logic          w_head_v, w_head_id, w_free0, w_free1;
  logic          w_capture, w_advance, w_grant, w_issue;
  logic [IW-1:0] w_count;

  assign w_head_v  = tag_v_q[LATENCY-1];
  assign w_head_id = tag_id_q[LATENCY-1];
  assign w_free0   = !rsp0_valid_q || rsp0_ready_i;
  assign w_free1   = !rsp1_valid_q || rsp1_ready_i;
  assign w_capture = w_head_v && (w_head_id ? w_free1 : w_free0);
  // An empty head never blocks; a full head only moves once its owner can take it.
  assign w_advance = !w_head_v || w_capture;

  assign w_grant = (req0_valid_i && req1_valid_i) ? !last_grant_q : req1_valid_i;
  assign w_issue = w_advance && !reset_i && (req0_valid_i || req1_valid_i);

  assign req0_ready_o  = w_issue && !w_grant;
  assign req1_ready_o  = w_issue && w_grant;
  assign unit_enable_o = w_advance && !reset_i;
  assign unit_in_o     = !w_issue ? '0 : (w_grant ? req1_data_i : req0_data_i);

  always_comb begin
    tag_v_d      = tag_v_q;
    tag_id_d     = tag_id_q;
    last_grant_d = last_grant_q;
    if (w_advance) begin
      tag_v_d  = {tag_v_q[LATENCY-2:0], w_issue};
      tag_id_d = {tag_id_q[LATENCY-2:0], w_grant};
    end
    if (w_issue) last_grant_d = w_grant;

    rsp0_valid_d = rsp0_valid_q && !rsp0_ready_i;
    rsp0_data_d  = rsp0_data_q;
    rsp1_valid_d = rsp1_valid_q && !rsp1_ready_i;
    rsp1_data_d  = rsp1_data_q;
    if (w_capture && !w_head_id) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = unit_out_i;
    end
    if (w_capture && w_head_id) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = unit_out_i;
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < LATENCY; i++) w_count = w_count + IW'(tag_v_q[i]);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      last_grant_q <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      last_grant_q <= last_grant_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign rsp0_valid_o = rsp0_valid_q;
  assign rsp1_valid_o = rsp1_valid_q;
  assign rsp0_data_o  = rsp0_data_q;
  assign rsp1_data_o  = rsp1_data_q;
  assign in_flight_o  = reset_i ? '0 : w_count;
  assign busy_o       = !reset_i && ((|tag_v_q) || rsp0_valid_q || rsp1_valid_q);

endmodule
`default_nettype wire

// File: tb/tb_exp_unit_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_exp_unit_arbiter: directed bench with unit model (In1+1, LATENCY deep)  |
// | and per-requester result scoreboards. r1.0                                 |
// +----------------------------------------------------------------------------+
module tb_exp_unit_arbiter;
  localparam int W  = 32;
  localparam int L  = 30;
  localparam int IW = $clog2(L + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, unit_enable, busy;
  logic [W-1:0] rsp0_data, rsp1_data, unit_in, unit_out;
  logic [IW-1:0] in_flight;

  exp_unit_arbiter #(.WIDTH(W), .LATENCY(L)) dut (
    .clock_i(clk), .reset_i(rst),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_data_i(req0_data),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_data_i(req1_data),
    .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready), .rsp0_data_o(rsp0_data),
    .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready), .rsp1_data_o(rsp1_data),
    .unit_enable_o(unit_enable), .unit_in_o(unit_in), .unit_out_i(unit_out),
    .in_flight_o(in_flight), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Function unit model: In1 + 1, delayed by L enabled edges.
  logic [W-1:0] pipe [L];
  always @(posedge clk) begin
    if (unit_enable) begin
      pipe[0] <= unit_in + 1;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign unit_out = pipe[L-1];

  int total = 0;
  int bad = 0;
  int del0 = 0, del1 = 0;
  logic [W-1:0] q0[$], q1[$];
  int gq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: push expected results on accepted operands, pop on delivered results.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (req0_valid && req0_ready) begin q0.push_back(req0_data + 1); gq.push_back(0); end
      if (req1_valid && req1_ready) begin q1.push_back(req1_data + 1); gq.push_back(1); end
      if (rsp0_valid && rsp0_ready) begin
        del0++;
        if (q0.size() == 0) chk("rsp0_unexpected", 64'(rsp0_data), 64'hdead);
        else chk("rsp0_data", 64'(rsp0_data), 64'(q0.pop_front()));
      end
      if (rsp1_valid && rsp1_ready) begin
        del1++;
        if (q1.size() == 0) chk("rsp1_unexpected", 64'(rsp1_data), 64'hdead);
        else chk("rsp1_data", 64'(rsp1_data), 64'(q1.pop_front()));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    chk("rst_unit_enable", 64'(unit_enable), 0);
    chk("rst_req_ready", 64'({req0_ready, req1_ready}), 0);
    chk("rst_in_flight", 64'(in_flight), 0);
    chk("rst_busy", 64'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int b0, b1, gb, first_v, last_v, cnt, n0, n1, err;
    for (int i = 0; i < L; i++) pipe[i] = '0;
    repeat (2) @(posedge clk);
    #1;

    // Single operation, latency and in_flight
    do_reset();
    chk("t1_rsp_valid_after_reset", 64'({rsp0_valid, rsp1_valid}), 0);
    b0 = del0; first_v = -1; err = 0;
    for (int k = 0; k <= 40; k++) begin
      req0_valid = (k == 0); req0_data = 5;
      @(negedge clk);
      if (k == 0) begin
        chk("t1_req0_ready", 64'(req0_ready), 1);
        chk("t1_unit_in", 64'(unit_in), 5);
      end
      if (k >= 1 && k <= 30 && in_flight != 1) err++;
      if (rsp0_valid && first_v < 0) first_v = k;
      if (k == 31) chk("t1_rsp0_data", 64'(rsp0_data), 6);
      step();
    end
    chk("t1_in_flight_errors", 64'(err), 0);
    chk("t1_latency", 64'(first_v), 31);
    chk("t1_count", 64'(del0 - b0), 1);

    // Tie: alternating grants, one result per cycle after fill
    do_reset();
    b0 = del0; b1 = del1; gb = gq.size(); n0 = 0; n1 = 0;
    first_v = -1; last_v = -1; cnt = 0;
    for (int k = 0; k <= 70; k++) begin
      req0_valid = (n0 < 8); req0_data = 100 + n0;
      req1_valid = (n1 < 8); req1_data = 200 + n1;
      @(negedge clk);
      if (req0_valid && req0_ready) n0++;
      if (req1_valid && req1_ready) n1++;
      if (rsp0_valid || rsp1_valid) begin
        cnt++; last_v = k;
        if (first_v < 0) first_v = k;
      end
      step();
    end
    chk("t2_grant0", 64'(gq[gb]), 0);
    chk("t2_grant1", 64'(gq[gb+1]), 1);
    chk("t2_grant2", 64'(gq[gb+2]), 0);
    chk("t2_grant3", 64'(gq[gb+3]), 1);
    err = 0;
    for (int i = 0; i < 16; i++) if (gb + i >= gq.size() || gq[gb+i] != (i % 2)) err++;
    chk("t2_grant_alternation", 64'(err), 0);
    chk("t2_first_result", 64'(first_v), 31);
    chk("t2_last_result", 64'(last_v), 46);
    chk("t2_result_cycles", 64'(cnt), 16);
    chk("t2_count", 64'((del0 - b0) + (del1 - b1)), 16);

    // Backpressure on requester 1
    do_reset();
    b1 = del1; err = 0;
    for (int k = 0; k <= 50; k++) begin
      req1_valid = (k < 4); req1_data = k + 1;
      rsp1_ready = !(k >= 20 && k < 40);
      req0_valid = (k == 35); req0_data = 77;
      @(negedge clk);
      if (k < 4 && !req1_ready) err++;
      if (k == 35) begin
        chk("t3_held_valid", 64'(rsp1_valid), 1);
        chk("t3_held_data", 64'(rsp1_data), 2);
        chk("t3_unit_enable", 64'(unit_enable), 0);
        chk("t3_req0_ready", 64'(req0_ready), 0);
        chk("t3_in_flight", 64'(in_flight), 3);
      end
      step();
    end
    chk("t3_issue", 64'(err), 0);
    chk("t3_count", 64'(del1 - b1), 4);
    chk("t3_idle", 64'(busy), 0);

    // Stall with requester 0 queued behind requester 1's head
    do_reset();
    b0 = del0; b1 = del1; first_v = -1;
    for (int k = 0; k <= 70; k++) begin
      req1_valid = (k < 2); req1_data = 10 + k;
      req0_valid = (k >= 2 && k < 5); req0_data = 20 + k - 2;
      rsp1_ready = (k >= 50);
      @(negedge clk);
      if (k == 40) begin
        chk("t4_rsp0_held_off", 64'(rsp0_valid), 0);
        chk("t4_unit_enable", 64'(unit_enable), 0);
      end
      if (rsp0_valid && first_v < 0) first_v = k;
      step();
    end
    chk("t4_first_rsp0", 64'(first_v), 52);
    chk("t4_count0", 64'(del0 - b0), 3);
    chk("t4_count1", 64'(del1 - b1), 2);

    // Reset mid-operation
    do_reset();
    b0 = del0; first_v = -1; err = 0;
    for (int k = 0; k <= 55; k++) begin
      rst = (k == 15);
      req0_valid = (k < 10 || k == 15 || k == 17);
      req0_data = (k == 17) ? 7 : k;
      @(negedge clk);
      if (k == 15) begin
        chk("t5_rst_enable", 64'(unit_enable), 0);
        chk("t5_rst_ready", 64'(req0_ready), 0);
        chk("t5_rst_in_flight", 64'(in_flight), 0);
        chk("t5_rst_busy", 64'(busy), 0);
      end
      if (k == 16) begin
        chk("t5_post_in_flight", 64'(in_flight), 0);
        chk("t5_post_busy", 64'(busy), 0);
        chk("t5_post_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 0);
      end
      if (k > 15 && rsp0_valid && first_v < 0) first_v = k;
      if (k == 48) chk("t5_fresh_data", 64'(rsp0_data), 8);
      step();
    end
    chk("t5_fresh_latency", 64'(first_v), 48);
    chk("t5_count", 64'(del0 - b0), 1);

    // Full back-to-back stream
    do_reset();
    b0 = del0; last_v = -1; err = 0; cnt = 0;
    for (int k = 0; k <= 100; k++) begin
      req0_valid = (k < 64); req0_data = 1000 + k;
      @(negedge clk);
      if (k < 64 && !req0_ready) err++;
      if (k <= 94 && !unit_enable) cnt++;
      if (rsp0_valid) last_v = k;
      step();
    end
    chk("t6_issue", 64'(err), 0);
    chk("t6_enable_drops", 64'(cnt), 0);
    chk("t6_last_result", 64'(last_v), 64 + L);
    chk("t6_count", 64'(del0 - b0), 64);

    chk("sb_q0_empty", 64'(q0.size()), 0);
    chk("sb_q1_empty", 64'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
`default_nettype wire
